// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, payload width and the rx_ctrl FSM encoding.
package uart_pkg;

    localparam int CYCLES_PER_BIT = 5000;
    localparam int PAYLOAD_BITS   = 8;

    typedef enum logic [1:0] {
        RXC_OFF = 2'd0,
        RXC_RUN = 2'd1,
        RXC_BRK = 2'd2
    } rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock receive FIFO with a registered head stage.
// Storage is a plain array written on push and read through a register, so it
// maps onto block/distributed RAM with read-before-write behaviour. A byte
// written at one edge becomes visible at the head one edge later.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   head_valid_o,
    output logic [WIDTH-1:0]       head_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] avail;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign level    = wr_cnt_q - rd_cnt_q;
    assign full     = (level == CNT_W'(DEPTH));
    assign pop_ok   = pop_i & head_valid_q;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok  = push_i & (~full | pop_ok);
    assign wr_cnt_d = wr_cnt_q + CNT_W'(push_ok);
    assign rd_cnt_d = rd_cnt_q + CNT_W'(pop_ok);
    // Entries already in memory before this edge that survive the pop; a byte
    // written at this edge is not counted, which gives the one-edge head delay.
    assign avail        = level - CNT_W'(pop_ok);
    assign head_valid_d = (avail != '0);

    // Counters and head-valid flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_cnt_q[PTR_W-1:0]] <= data_i;
        end
    end

    // Registered head read; holds its value while no entry is available.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_data_q <= '0;
        end else if (head_valid_d) begin
            head_data_q <= mem_q[rd_cnt_d[PTR_W-1:0]];
        end
    end

    assign full_o       = full;
    assign empty_o      = (level == '0);
    assign level_o      = level;
    assign head_valid_o = head_valid_q;
    assign head_data_o  = head_data_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enables the receiver, filters BREAK bytes, buffers
// received bytes and presents them on a valid/ready stream with sticky status.
// Optional feature: define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout
// counter; otherwise idle_timeout is tied low.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS,
    parameter int IDLE_TIMEOUT = 10 * uart_pkg::CYCLES_PER_BIT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ctrl_enable,
    input  logic                         clr_status,
    input  logic                         rx_valid,
    input  logic                         rx_break,
    input  logic [PAYLOAD_BITS-1:0]      rx_data,
    output logic                         rx_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [PAYLOAD_BITS-1:0]      m_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         break_seen,
    output logic                         idle_timeout
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 131071) begin : g_bad_timeout
        $error("uart_rx_ctrl: IDLE_TIMEOUT must fit the 17-bit idle counter");
    end

    rx_ctrl_state_e state_q, state_d;
    logic           active;
    logic           push_req;
    logic           brk_evt;
    logic           pop_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           overflow_q, overflow_d;
    logic           break_seen_q, break_seen_d;

    // Bytes are taken only while the receiver is enabled; a byte arriving in
    // the cycle ctrl_enable drops is still accepted since state_q is not OFF.
    assign active   = (state_q != RXC_OFF);
    assign push_req = active & rx_valid & ~rx_break;
    assign brk_evt  = active & rx_valid & rx_break;
    assign pop_req  = m_valid & m_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RXC_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; dropping ctrl_enable overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RXC_OFF: if (ctrl_enable) state_d = RXC_RUN;
            RXC_RUN: if (rx_valid && rx_break) state_d = RXC_BRK;
            RXC_BRK: if (rx_valid && !rx_break) state_d = RXC_RUN;
            default: state_d = RXC_OFF;
        endcase
        if (!ctrl_enable) begin
            state_d = RXC_OFF;
        end
    end

    // Sticky status next state; a set event in the clearing cycle wins.
    always_comb begin
        overflow_d   = (overflow_q & ~clr_status) | (push_req & fifo_full & ~pop_req);
        break_seen_d = (break_seen_q & ~clr_status) | brk_evt;
    end

    // Sticky status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_q   <= 1'b0;
            break_seen_q <= 1'b0;
        end else begin
            overflow_q   <= overflow_d;
            break_seen_q <= break_seen_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push_req),
        .data_i       (rx_data),
        .pop_i        (pop_req),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .level_o      (fifo_level),
        .head_valid_o (m_valid),
        .head_data_o  (m_data)
    );

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam logic [16:0] IDLE_LIMIT = 17'(IDLE_TIMEOUT);

    logic [16:0] idle_cnt_q, idle_cnt_d;
    logic        idle_pulse_q, idle_pulse_d;

    // Idle counter: restarts on traffic or when off, saturates at the limit;
    // the pulse fires only on the cycle the limit is first reached.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (push_req || state_q == RXC_OFF) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LIMIT) begin
            idle_cnt_d = idle_cnt_q + 17'd1;
        end
        idle_pulse_d = (idle_cnt_d == IDLE_LIMIT) && (idle_cnt_q != IDLE_LIMIT) && !fifo_empty;
    end

    // Idle counter and pulse registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idle_cnt_q   <= '0;
            idle_pulse_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            idle_pulse_q <= idle_pulse_d;
        end
    end

    assign idle_timeout = idle_pulse_q;
`else
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;
    assign idle_timeout      = 1'b0;
`endif

    assign rx_en      = active;
    assign overflow   = overflow_q;
    assign break_seen = break_seen_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (FIFO_DEPTH=4, IDLE_TIMEOUT=100).
// Honours UART_RX_CTRL_TIMEOUT_EN when the same macro is given to the bench.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ctrl_enable = 1'b0;
    logic       clr_status = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_break = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       break_seen;
    logic       idle_timeout;

    int checks = 0;
    int errors = 0;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int EXP_PULSE_AT = 100;
`else
    localparam int EXP_PULSE_AT = -1;
`endif

    uart_rx_ctrl #(
        .FIFO_DEPTH   (4),
        .PAYLOAD_BITS (8),
        .IDLE_TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ctrl_enable  (ctrl_enable),
        .clr_status   (clr_status),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .break_seen   (break_seen),
        .idle_timeout (idle_timeout)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL reset_rx_en got %b exp 0", rx_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if ({overflow, break_seen, idle_timeout} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {overflow, break_seen, idle_timeout}); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        ctrl_enable = 1'b1;
        tick();
        checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL enable_rx_en got %b exp 1", rx_en); end
        m_ready  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        checks++; if ({m_valid, fifo_level} !== {1'b0, 3'd1}) begin errors++; $display("FAIL single_latency got v=%b lvl=%0d exp v=0 lvl=1", m_valid, fifo_level); end
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL single_out got v=%b d=%h exp v=1 d=5a", m_valid, m_data); end
        $display("rx byte %h", m_data);
        tick();
        checks++; if ({m_valid, fifo_level} !== {1'b0, 3'd0}) begin errors++; $display("FAIL single_drain got v=%b lvl=%0d exp v=0 lvl=0", m_valid, fifo_level); end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        checks++; if ({fifo_level, overflow} !== {3'd4, 1'b1}) begin errors++; $display("FAIL ovf_level got lvl=%0d ovf=%b exp lvl=4 ovf=1", fifo_level, overflow); end
        checks++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL ovf_head got v=%b d=%h exp v=1 d=01", m_valid, m_data); end
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL ovf_hold got v=%b d=%h exp v=1 d=01", m_valid, m_data); end
        m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({m_valid, m_data} !== {1'b1, 8'(k)}) begin errors++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", k, m_valid, m_data, 8'(k)); end
            $display("rx byte %h", m_data);
            tick();
        end
        checks++; if ({m_valid, fifo_level} !== {1'b0, 3'd0}) begin errors++; $display("FAIL ovf_empty got v=%b lvl=%0d exp v=0 lvl=0", m_valid, fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hA4; exp_seq[3] = 8'hA5;
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'hA0 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        checks++; if ({fifo_level, m_data} !== {3'd4, 8'hA1}) begin errors++; $display("FAIL full_pre got lvl=%0d d=%h exp lvl=4 d=a1", fifo_level, m_data); end
        m_ready  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        rx_valid = 1'b0;
        m_ready  = 1'b0;
        checks++; if ({fifo_level, overflow} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_pushpop got lvl=%0d ovf=%b exp lvl=4 ovf=0", fifo_level, overflow); end
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({m_valid, m_data} !== {1'b1, exp_seq[k]}) begin errors++; $display("FAIL full_order%0d got v=%b d=%h exp v=1 d=%h", k, m_valid, m_data, exp_seq[k]); end
            $display("rx byte %h", m_data);
            tick();
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL full_empty got lvl=%0d exp 0", fifo_level); end
    endtask

    task automatic test_break();
        m_ready  = 1'b1;
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data  = 8'h00;
        tick();
        checks++; if ({break_seen, fifo_level} !== {1'b1, 3'd0}) begin errors++; $display("FAIL brk_first got bs=%b lvl=%0d exp bs=1 lvl=0", break_seen, fifo_level); end
        tick();
        tick();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL brk_discard got lvl=%0d exp 0", fifo_level); end
        rx_break = 1'b0;
        rx_data  = 8'h33;
        tick();
        rx_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL brk_resume got lvl=%0d exp 1", fifo_level); end
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL brk_out got v=%b d=%h exp v=1 d=33", m_valid, m_data); end
        $display("rx byte %h", m_data);
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL brk_only_one got v=%b exp 0", m_valid); end
        clr_status = 1'b1;
        rx_valid   = 1'b1;
        rx_break   = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_break = 1'b0;
        checks++; if (break_seen !== 1'b1) begin errors++; $display("FAIL brk_set_wins got %b exp 1", break_seen); end
        tick();
        clr_status = 1'b0;
        checks++; if (break_seen !== 1'b0) begin errors++; $display("FAIL brk_clear got %b exp 0", break_seen); end
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        tick();
        rx_valid = 1'b0;
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'h44}) begin errors++; $display("FAIL brk_exit got v=%b d=%h exp v=1 d=44", m_valid, m_data); end
        $display("rx byte %h", m_data);
        tick();
    endtask

    task automatic test_disable_drain();
        m_ready  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hB1;
        tick();
        rx_data  = 8'hB2;
        tick();
        rx_data     = 8'hB3;
        ctrl_enable = 1'b0;
        tick();
        checks++; if ({rx_en, fifo_level} !== {1'b0, 3'd3}) begin errors++; $display("FAIL dis_off got en=%b lvl=%0d exp en=0 lvl=3", rx_en, fifo_level); end
        rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL dis_ignore got lvl=%0d exp 3", fifo_level); end
        checks++; if ({m_valid, m_data} !== {1'b1, 8'hB1}) begin errors++; $display("FAIL dis_head got v=%b d=%h exp v=1 d=b1", m_valid, m_data); end
        m_ready = 1'b1;
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'hB2}) begin errors++; $display("FAIL dis_drain2 got v=%b d=%h exp v=1 d=b2", m_valid, m_data); end
        tick();
        checks++; if ({m_valid, m_data} !== {1'b1, 8'hB3}) begin errors++; $display("FAIL dis_drain3 got v=%b d=%h exp v=1 d=b3", m_valid, m_data); end
        resetn = 1'b0;
        tick();
        checks++; if ({m_valid, fifo_level, rx_en} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL dis_reset got v=%b lvl=%0d en=%b exp v=0 lvl=0 en=0", m_valid, fifo_level, rx_en); end
        resetn  = 1'b1;
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_idle_timeout();
        int pulse_at;
        int pulses;
        ctrl_enable = 1'b1;
        m_ready     = 1'b0;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hC7;
        tick();
        rx_valid = 1'b0;
        pulse_at = -1;
        pulses   = 0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (idle_timeout === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
            end
        end
        checks++; if (pulse_at !== EXP_PULSE_AT) begin errors++; $display("FAIL idle_pulse_time got %0d exp %0d", pulse_at, EXP_PULSE_AT); end
        checks++; if (pulses !== (EXP_PULSE_AT > 0 ? 1 : 0)) begin errors++; $display("FAIL idle_pulse_count got %0d exp %0d", pulses, (EXP_PULSE_AT > 0 ? 1 : 0)); end
        m_ready = 1'b1;
        tick();
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hC8;
        tick();
        rx_valid = 1'b0;
        pulses   = 0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (idle_timeout === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_empty got %0d pulses exp 0", pulses); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL idle_drained got lvl=%0d exp 0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_full_push_pop();
        test_break();
        test_disable_drain();
        test_idle_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
